// File: rtl/johnson_counter_param.sv
// Parameterised Johnson (twisted-ring) counter.
// Besides the ring itself, the block keeps a binary phase index in step with
// the code. It flags a one-cycle wrap pulse at the sequence boundary and
// detects any ring value that is not one of the 2*WIDTH legal codes, then
// recovers from it.
// WIDTH must lie in 2..16.
module johnson_counter_param #(
  parameter int WIDTH = 5,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam int PERIOD = 2 * WIDTH;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PERIOD - 1);

  // Johnson code for phase k.
  // For k up to WIDTH, the low k bits are set.
  // Above WIDTH, the ones are drained from the bottom: bits at or above k-WIDTH stay set.
  function automatic logic [WIDTH-1:0] legal_code(input logic [PW-1:0] k);
    logic [WIDTH-1:0] code;
    int               kk;
    kk   = int'(k);
    code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      code[i] = (kk <= WIDTH) ? (i < kk) : (i >= kk - WIDTH);
    end
    return code;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             illegal_code;
  logic             load_in_range;

  // Flag the ring as illegal when it matches none of the 2*WIDTH legal codes.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < PERIOD; k++) begin
      if (q_q == legal_code(PW'(k))) hit = 1'b1;
    end
    illegal_code = ~hit;
  end

  // A load target outside 0..2*WIDTH-1 is ignored so that no illegal state can be created.
  assign load_in_range = ({1'b0, load_phase} < (PW + 1)'(PERIOD));

  // Next-state selection.
  // Priority is clear, then load, then illegal recovery, then step, then hold.
  // wrap is raised only by a step that crosses the boundary.
  always_comb begin
    q_d     = q_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (clear) begin
      q_d     = '0;
      phase_d = '0;
    end else if (load) begin
      if (load_in_range) begin
        q_d     = legal_code(load_phase);
        phase_d = load_phase;
      end
    end else if (illegal_code) begin
      q_d     = '0;
      phase_d = '0;
    end else if (enable) begin
      if (!dir) begin
        q_d     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
        wrap_d  = (phase_q == LAST_PHASE);
      end else begin
        q_d     = {~q_q[0], q_q[WIDTH-1:1]};
        phase_d = (phase_q == '0) ? LAST_PHASE : phase_q - 1'b1;
        wrap_d  = (phase_q == '0);
      end
    end
  end

  // Register the ring, the phase index and the wrap pulse.
  // Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q       = q_q;
  assign phase   = phase_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_code;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Bench for johnson_counter_param.
// The main instance uses WIDTH=5. Two further instances, with WIDTH=2 and
// WIDTH=16, check the full period at the extremes of the legal width range.
module tb_johnson_counter_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=5 instance ----------------
  logic       en5 = 1'b0, dir5 = 1'b0, clr5 = 1'b0, ld5 = 1'b0;
  logic [3:0] lp5 = '0;
  logic [4:0] q5;
  logic [3:0] ph5;
  logic       wrap5, ill5;

  johnson_counter_param #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .enable(en5), .dir(dir5), .clear(clr5),
    .load(ld5), .load_phase(lp5), .q(q5), .phase(ph5), .wrap(wrap5),
    .illegal(ill5)
  );

  // ---------------- WIDTH=2 / WIDTH=16 instances ----------------
  logic        en_alt = 1'b0;
  logic        zero1 = 1'b0;
  logic [1:0]  lp2 = '0;
  logic [4:0]  lp16 = '0;
  logic [1:0]  q2;
  logic [1:0]  ph2;
  logic        wrap2, ill2;
  logic [15:0] q16;
  logic [4:0]  ph16;
  logic        wrap16, ill16;

  johnson_counter_param #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en_alt), .dir(zero1), .clear(zero1),
    .load(zero1), .load_phase(lp2), .q(q2), .phase(ph2), .wrap(wrap2),
    .illegal(ill2)
  );

  johnson_counter_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(en_alt), .dir(zero1), .clear(zero1),
    .load(zero1), .load_phase(lp16), .q(q16), .phase(ph16), .wrap(wrap16),
    .illegal(ill16)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference Johnson code, built from shifted masks.
  function automatic logic [15:0] ref_code(input int w, input int k);
    logic [31:0] v;
    if (k <= w) v = (32'd1 << k) - 32'd1;
    else        v = ((32'd1 << w) - 32'd1) & (32'hffff_ffff << (k - w));
    return v[15:0];
  endfunction

  // ---------------- stimulus table ----------------
  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lp;
    logic       en;
    logic       dr;
    logic [4:0] eq;
    logic [3:0] ep;
    logic       ew;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic ld, input logic [3:0] lp,
                              input logic en, input logic dr, input logic [4:0] eq,
                              input logic [3:0] ep, input logic ew);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lp = lp; v.en = en; v.dr = dr;
    v.eq = eq; v.ep = ep; v.ew = ew;
    return v;
  endfunction

  vec_t tbl[$];

  // ---------------- scoreboard ----------------
  // Packed expectation: {q[4:0], phase[3:0], wrap, illegal}
  logic [10:0] exp_q[$];

  task automatic compare_w5(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".q"},       32'(q5),    32'(e[10:6]));
    check({tag, ".phase"},   32'(ph5),   32'(e[5:2]));
    check({tag, ".wrap"},    32'(wrap5), 32'(e[1]));
    check({tag, ".illegal"}, 32'(ill5),  32'(e[0]));
  endtask

  task automatic step_w5(input vec_t v, input string tag);
    @(negedge clk);
    clr5 = v.clr; ld5 = v.ld; lp5 = v.lp; en5 = v.en; dir5 = v.dr;
    exp_q.push_back({v.eq, v.ep, v.ew, 1'b0});
    @(posedge clk);
    #1;
    compare_w5(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p2, p16;
    logic ew2, ew16;

    // forward through the full period (10 steps)
    tbl.push_back(mk(0,0,0,1,0,5'b00001,4'd1,0));
    tbl.push_back(mk(0,0,0,1,0,5'b00011,4'd2,0));
    tbl.push_back(mk(0,0,0,1,0,5'b00111,4'd3,0));
    tbl.push_back(mk(0,0,0,1,0,5'b01111,4'd4,0));
    tbl.push_back(mk(0,0,0,1,0,5'b11111,4'd5,0));
    tbl.push_back(mk(0,0,0,1,0,5'b11110,4'd6,0));
    tbl.push_back(mk(0,0,0,1,0,5'b11100,4'd7,0));
    tbl.push_back(mk(0,0,0,1,0,5'b11000,4'd8,0));
    tbl.push_back(mk(0,0,0,1,0,5'b10000,4'd9,0));
    tbl.push_back(mk(0,0,0,1,0,5'b00000,4'd0,1));
    // reverse from phase 0 wraps to 9
    tbl.push_back(mk(0,0,0,1,1,5'b10000,4'd9,1));
    tbl.push_back(mk(0,0,0,1,1,5'b11000,4'd8,0));
    // hold
    tbl.push_back(mk(0,0,0,0,1,5'b11000,4'd8,0));
    // direction change with no dead cycle
    tbl.push_back(mk(0,0,0,1,0,5'b10000,4'd9,0));
    tbl.push_back(mk(0,0,0,1,0,5'b00000,4'd0,1));
    // load / out-of-range load / clear over load
    tbl.push_back(mk(0,1,4'd7,1,0,5'b11100,4'd7,0));
    tbl.push_back(mk(0,1,4'd12,1,0,5'b11100,4'd7,0));
    tbl.push_back(mk(1,1,4'd3,1,1,5'b00000,4'd0,0));
    tbl.push_back(mk(0,1,4'd10,1,0,5'b00000,4'd0,0));
    tbl.push_back(mk(0,1,4'd9,0,0,5'b10000,4'd9,0));
    tbl.push_back(mk(0,0,0,1,0,5'b00000,4'd0,1));
    tbl.push_back(mk(0,1,4'd0,1,0,5'b00000,4'd0,0));
    tbl.push_back(mk(0,1,4'd5,0,0,5'b11111,4'd5,0));
    tbl.push_back(mk(0,0,0,1,1,5'b01111,4'd4,0));

    // reset state, checked while rst_n is still low
    #12;
    check("reset.q",       32'(q5),    32'd0);
    check("reset.phase",   32'(ph5),   32'd0);
    check("reset.wrap",    32'(wrap5), 32'd0);
    check("reset.illegal", 32'(ill5),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step_w5(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset between edges at phase 6
    step_w5(mk(0,1,4'd6,0,0,5'b11110,4'd6,0), "pre_rst");
    @(negedge clk);
    ld5 = 1'b0; en5 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.q",     32'(q5),    32'd0);
    check("async_rst.phase", 32'(ph5),   32'd0);
    check("async_rst.wrap",  32'(wrap5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_w5(mk(0,0,0,1,0,5'b00001,4'd1,0), "post_rst");

    // illegal ring value recovers to phase 0 with enable low
    step_w5(mk(0,1,4'd3,0,0,5'b00111,4'd3,0), "pre_ill");
    @(negedge clk);
    ld5 = 1'b0; en5 = 1'b0;
    force dut5.q_q = 5'b01010;
    #1;
    check("ill_flag", 32'(ill5), 32'd1);
    release dut5.q_q;
    exp_q.push_back({5'b00000, 4'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    compare_w5("ill_recover");

    // full period at WIDTH=2 and WIDTH=16 from reset
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    p2 = 0; p16 = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      en_alt = 1'b1;
      ew2  = (p2 == 3);
      ew16 = (p16 == 31);
      p2   = (p2 + 1) % 4;
      p16  = (p16 + 1) % 32;
      @(posedge clk);
      #1;
      check($sformatf("w2.q[%0d]", c),      32'(q2),     32'(ref_code(2, p2)));
      check($sformatf("w2.phase[%0d]", c),  32'(ph2),    32'(p2));
      check($sformatf("w2.wrap[%0d]", c),   32'(wrap2),  32'(ew2));
      check($sformatf("w16.q[%0d]", c),     32'(q16),    32'(ref_code(16, p16)));
      check($sformatf("w16.phase[%0d]", c), 32'(ph16),   32'(p16));
      check($sformatf("w16.wrap[%0d]", c),  32'(wrap16), 32'(ew16));
      check($sformatf("w16.ill[%0d]", c),   32'(ill16),  32'd0);
    end
    en_alt = 1'b0;

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck simulation
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/johnson_counter_param.md
JOHNSON_COUNTER_PARAM -- requirements
Module: johnson_counter_param

Interface
REQ-001 Parameter: WIDTH, default 5, number of flip-flops in the ring; legal range 2..16.
REQ-002 Derived constant: PW = $clog2(2*WIDTH), the phase index width (PW=4 for WIDTH=5).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  when high, advance one phase per clock.
REQ-006 dir  input  1  0 = forward (shift left, ~MSB into LSB); 1 = reverse (shift right, ~LSB into MSB).
REQ-007 clear  input  1  synchronous return to phase 0.
REQ-008 load  input  1  synchronous preset to load_phase.
REQ-009 load_phase  input  PW  target phase index for load.
REQ-010 q  output  WIDTH  registered Johnson code.
REQ-011 phase  output  PW  registered binary phase index 0..2*WIDTH-1, always consistent with q.
REQ-012 wrap  output  1  registered one-cycle pulse on sequence wrap-around.
REQ-013 illegal  output  1  combinational flag: q is not one of the 2*WIDTH legal codes.

Function
REQ-014 Legal code for phase k, 0<=k<=WIDTH: q = (2^k)-1, giving low k bits set.
REQ-015 Legal code for phase k, WIDTH<k<=2*WIDTH-1: q = all-ones shifted left by (k-WIDTH), masked to WIDTH bits.
REQ-016 Forward step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]} and phase <= (phase+1) mod 2*WIDTH.
REQ-017 Reverse step: q <= {~q[0], q[WIDTH-1:1]} and phase <= (phase-1) mod 2*WIDTH.
REQ-018 Per-clock priority, highest first: clear, load, illegal recovery, enable step, hold.
REQ-019 clear: q <= 0, phase <= 0, wrap <= 0; dominates load, enable and dir.
REQ-020 load, load_phase < 2*WIDTH: q <= legal code of load_phase, phase <= load_phase, wrap <= 0.
REQ-021 load, load_phase >= 2*WIDTH: q and phase hold, wrap <= 0; no illegal state is created.
REQ-022 Illegal recovery: if illegal=1 and neither clear nor load is active, q <= 0 and phase <= 0 at the next edge, independent of enable; wrap <= 0.
REQ-023 Step latency: new q and phase are visible one clock after the enable edge.
REQ-024 wrap = 1 for exactly the cycle after a forward step from phase 2*WIDTH-1 to 0, or a reverse step from 0 to 2*WIDTH-1.
REQ-025 wrap = 0 on every other cycle, including clear, load and recovery into phase 0.
REQ-026 A dir change takes effect on the next enabled edge; there is no pipeline or dead cycle.
REQ-027 enable=0 with no clear, load or illegal: q, phase hold; wrap <= 0.
REQ-028 Full period is 2*WIDTH enabled clocks in either direction.

Reset
REQ-029 rst_n low asynchronously forces q=0, phase=0, wrap=0 without waiting for a clock edge; illegal then reads 0.
REQ-030 Reset mid-sequence discards state; the first enabled edge after release steps from phase 0.
REQ-031 rst_n deassertion is synchronised externally; the block adds no reset synchroniser.

Verification
REQ-032 WIDTH=5, reset, then enable=1, dir=0 for 10 clocks -> q sequence 00001,00011,00111,01111,11111,11110,11100,11000,10000,00000; phase sequence 1..9 then 0; wrap high only in the cycle showing 00000.
REQ-033 WIDTH=5, from phase 0: dir=1, enable=1 for one clock -> q=10000, phase=9, wrap=1; next clock -> q=11000, phase=8, wrap=0.
REQ-034 load=1, load_phase=7, enable=1 -> q=11100, phase=7. Next cycle load_phase=12 -> q and phase unchanged. Next cycle clear=1 with load=1 -> q=00000, phase=0.
REQ-035 Force q=01010 (illegal) with enable=0 -> illegal=1; next edge q=00000, phase=0, illegal=0, wrap=0.
REQ-036 Assert rst_n=0 between clock edges at phase 6 -> q=0, phase=0 immediately. Release, one enabled edge -> q=00001.
REQ-037 Repeat REQ-032 with WIDTH=2 and WIDTH=16 -> period 4 and 32 respectively; phase stays consistent with q on every cycle, checked against the REQ-014/015 mapping.
